inputc: RTL and testbench

INPUTC -- requirements
Module: inputc

---
 rtl/inputc.sv | 121 ++++++++++++
 tb/tb_inputc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inputc.sv
// Router input channel: a small flit FIFO, XY route computation and a
// two-state packet FSM that requests the switch and returns credits upstream.
module inputc #(
  parameter int PORT_N = 5,
  parameter int DATA_W = 32,
  parameter int XY_W   = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+2:0] inputc_i,
  output logic              inputc_o,
  input  logic              wire_i,
  output logic [DATA_W+2:0] wire_o,
  output logic [PORT_N-1:0] port_o,
  output logic              req_o,
  input  logic [XY_W-1:0]   my_xpos,
  input  logic [XY_W-1:0]   my_ypos
);

  localparam int FLIT_W = DATA_W + 2;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  localparam logic [1:0] FT_HEAD  = 2'b00;
  localparam logic [1:0] FT_TAIL  = 2'b10;
  localparam logic [1:0] FT_HTAIL = 2'b11;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [0:0]        state_q;
  logic [PORT_N-1:0] route_q;
  logic [PORT_N-1:0] route_comb;

  logic              in_valid;
  logic              empty, full;
  logic [FLIT_W-1:0] front;
  logic [1:0]        front_ftype;
  logic              front_is_head;
  logic [XY_W-1:0]   dst_x, dst_y;
  logic              grant, discard, deq, wr_en;

  assign in_valid      = inputc_i[DATA_W+2];
  assign empty         = (count_q == '0);
  assign full          = (count_q == CNT_W'(DEPTH));
  assign front         = mem[rd_ptr_q];
  assign front_ftype   = front[FLIT_W-1:DATA_W];
  assign front_is_head = (front_ftype == FT_HEAD) || (front_ftype == FT_HTAIL);
  assign dst_x         = front[XY_W-1:0];
  assign dst_y         = front[2*XY_W-1:XY_W];

  // X is resolved before Y, so a packet only turns once on its way.
  always_comb begin
    route_comb = '0;
    if (dst_x > my_xpos)      route_comb[P_EAST]  = 1'b1;
    else if (dst_x < my_xpos) route_comb[P_WEST]  = 1'b1;
    else if (dst_y > my_ypos) route_comb[P_NORTH] = 1'b1;
    else if (dst_y < my_ypos) route_comb[P_SOUTH] = 1'b1;
    else                      route_comb[P_LOCAL] = 1'b1;
  end

  always_comb begin
    port_o = '0;
    if (state_q == ACTIVE)              port_o = route_q;
    else if (!empty && front_is_head)   port_o = route_comb;
  end

  assign req_o   = !empty && (port_o != '0);
  assign grant   = req_o && wire_i;
  // A stray body/tail flit with no open packet is dropped but still credited.
  assign discard = (state_q == IDLE) && !empty && !front_is_head;
  assign deq     = grant || discard;
  assign wr_en   = in_valid && (!full || deq);
  assign wire_o  = grant ? {1'b1, front} : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= inputc_i[FLIT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      inputc_o <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (deq)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q  <= count_q + CNT_W'(wr_en) - CNT_W'(deq);
      inputc_o <= deq;
    end
  end

  // Head-tail flits are single-flit packets, so they never open a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= '0;
    end else if (grant) begin
      if (state_q == IDLE && front_ftype == FT_HEAD) begin
        state_q <= ACTIVE;
        route_q <= route_comb;
      end else if (state_q == ACTIVE && front_ftype == FT_TAIL) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_inputc.sv
// Directed self-checking bench for the router input channel, with the router at (1,1).
module tb_inputc;

  logic        clk;
  logic        rst_n;
  logic [34:0] inputc_i;
  logic        inputc_o;
  logic        wire_i;
  logic [34:0] wire_o;
  logic [4:0]  port_o;
  logic        req_o;
  logic [1:0]  my_xpos, my_ypos;

  int n_compared;
  int n_failed;

  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

  inputc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inputc_i (inputc_i),
    .inputc_o (inputc_o),
    .wire_i   (wire_i),
    .wire_o   (wire_o),
    .port_o   (port_o),
    .req_o    (req_o),
    .my_xpos  (my_xpos),
    .my_ypos  (my_ypos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] mk(input logic [1:0] ft, input logic [31:0] d);
    return {1'b1, ft, d};
  endfunction

  function automatic logic [31:0] dd(input logic [15:0] tag, input logic [1:0] x, input logic [1:0] y);
    return {tag, 12'h000, y, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ft, input logic [31:0] d);
    inputc_i = mk(ft, d);
    step();
    inputc_i = '0;
  endtask

  task automatic grant_one();
    wire_i = 1'b1;
    step();
    wire_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    my_xpos  = 2'd1;
    my_ypos  = 2'd1;
    inputc_i = mk(HT, dd(16'hDEAD, 2'd3, 2'd1));
    wire_i   = 1'b1;
    #12;
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_req: got %b expected 0", req_o); end
    n_compared++;
    if (port_o !== 5'b0) begin n_failed++; $display("[TB] FAIL reset_port: got %b expected 00000", port_o); end
    n_compared++;
    if (wire_o !== 35'b0) begin n_failed++; $display("[TB] FAIL reset_wire: got %h expected 0", wire_o); end
    n_compared++;
    if (inputc_o !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_credit: got %b expected 0", inputc_o); end
    inputc_i = '0;
    wire_i   = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_input_ignored: req got %b expected 0", req_o); end
  endtask

  task automatic test_head_tail_east();
    logic [31:0] d;
    d = dd(16'h1234, 2'd3, 2'd1);
    push(HT, d);
    n_compared++;
    if (req_o !== 1'b1) begin n_failed++; $display("[TB] FAIL ht_req: got %b expected 1", req_o); end
    n_compared++;
    if (port_o !== 5'b00100) begin n_failed++; $display("[TB] FAIL ht_port: got %b expected 00100", port_o); end
    n_compared++;
    if (wire_o !== 35'b0) begin n_failed++; $display("[TB] FAIL ht_wire_idle: got %h expected 0", wire_o); end
    wire_i = 1'b1;
    #1;
    n_compared++;
    if (wire_o !== mk(HT, d)) begin n_failed++; $display("[TB] FAIL ht_wire: got %h expected %h", wire_o, mk(HT, d)); end
    step();
    wire_i = 1'b0;
    n_compared++;
    if (inputc_o !== 1'b1) begin n_failed++; $display("[TB] FAIL ht_credit: got %b expected 1", inputc_o); end
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL ht_req_after: got %b expected 0", req_o); end
    step();
    n_compared++;
    if (inputc_o !== 1'b0) begin n_failed++; $display("[TB] FAIL ht_credit_pulse: got %b expected 0", inputc_o); end
  endtask

  task automatic test_routes();
    logic [1:0] xs [3];
    logic [1:0] ys [3];
    logic [4:0] ex [3];
    xs = '{2'd0, 2'd1, 2'd1};
    ys = '{2'd2, 2'd0, 2'd1};
    ex = '{5'b10000, 5'b01000, 5'b00001};
    for (int i = 0; i < 3; i++) begin
      push(HEAD, dd(16'h0A00 + 16'(i), xs[i], ys[i]));
      n_compared++;
      if (port_o !== ex[i]) begin n_failed++; $display("[TB] FAIL route_%0d: got %b expected %b", i, port_o, ex[i]); end
      grant_one();
      n_compared++;
      if (port_o !== ex[i]) begin n_failed++; $display("[TB] FAIL route_latched_%0d: got %b expected %b", i, port_o, ex[i]); end
      n_compared++;
      if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL route_req_empty_%0d: got %b expected 0", i, req_o); end
      push(TAIL, 32'h0000_7A11);
      grant_one();
      n_compared++;
      if (port_o !== 5'b0) begin n_failed++; $display("[TB] FAIL route_idle_%0d: got %b expected 00000", i, port_o); end
    end
  endtask

  task automatic test_packet();
    logic [31:0] d [3];
    logic [1:0]  ft [3];
    d  = '{dd(16'h4EAD, 2'd2, 2'd1), 32'hB0D7_B0D7, 32'h7A11_7A11};
    ft = '{HEAD, BODY, TAIL};
    for (int i = 0; i < 3; i++) push(ft[i], d[i]);
    wire_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (wire_o !== mk(ft[i], d[i])) begin n_failed++; $display("[TB] FAIL pkt_wire_%0d: got %h expected %h", i, wire_o, mk(ft[i], d[i])); end
      n_compared++;
      if (port_o !== 5'b00100) begin n_failed++; $display("[TB] FAIL pkt_port_%0d: got %b expected 00100", i, port_o); end
      step();
      n_compared++;
      if (inputc_o !== 1'b1) begin n_failed++; $display("[TB] FAIL pkt_credit_%0d: got %b expected 1", i, inputc_o); end
    end
    wire_i = 1'b0;
    n_compared++;
    if (port_o !== 5'b0) begin n_failed++; $display("[TB] FAIL pkt_idle_port: got %b expected 00000", port_o); end
    step();
    n_compared++;
    if (inputc_o !== 1'b0) begin n_failed++; $display("[TB] FAIL pkt_credit_end: got %b expected 0", inputc_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = dd(16'hC000 + 16'(i), 2'd2, 2'd1);
    for (int i = 0; i < 5; i++) push(HT, d[i]);
    wire_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (wire_o !== mk(HT, d[i])) begin n_failed++; $display("[TB] FAIL ovf_wire_%0d: got %h expected %h", i, wire_o, mk(HT, d[i])); end
      step();
      n_compared++;
      if (inputc_o !== 1'b1) begin n_failed++; $display("[TB] FAIL ovf_credit_%0d: got %b expected 1", i, inputc_o); end
    end
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL ovf_req_empty: got %b expected 0", req_o); end
    n_compared++;
    if (wire_o !== 35'b0) begin n_failed++; $display("[TB] FAIL ovf_wire_empty: got %h expected 0", wire_o); end
    wire_i = 1'b0;
    step();
    n_compared++;
    if (inputc_o !== 1'b0) begin n_failed++; $display("[TB] FAIL ovf_no_fifth_credit: got %b expected 0", inputc_o); end
  endtask

  task automatic test_full_write();
    logic [31:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = dd(16'hF000 + 16'(i), 2'd3, 2'd1);
    for (int i = 0; i < 4; i++) push(HT, d[i]);
    inputc_i = mk(HT, d[4]);
    wire_i   = 1'b1;
    #1;
    n_compared++;
    if (wire_o !== mk(HT, d[0])) begin n_failed++; $display("[TB] FAIL full_wire_0: got %h expected %h", wire_o, mk(HT, d[0])); end
    step();
    inputc_i = '0;
    for (int i = 1; i < 5; i++) begin
      n_compared++;
      if (wire_o !== mk(HT, d[i])) begin n_failed++; $display("[TB] FAIL full_wire_%0d: got %h expected %h", i, wire_o, mk(HT, d[i])); end
      step();
    end
    wire_i = 1'b0;
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL full_req_empty: got %b expected 0", req_o); end
    step();
  endtask

  task automatic test_discard();
    push(BODY, 32'h5555_AAAA);
    wire_i = 1'b1;
    #1;
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL disc_req: got %b expected 0", req_o); end
    n_compared++;
    if (port_o !== 5'b0) begin n_failed++; $display("[TB] FAIL disc_port: got %b expected 00000", port_o); end
    n_compared++;
    if (wire_o !== 35'b0) begin n_failed++; $display("[TB] FAIL disc_wire: got %h expected 0", wire_o); end
    step();
    wire_i = 1'b0;
    n_compared++;
    if (inputc_o !== 1'b1) begin n_failed++; $display("[TB] FAIL disc_credit: got %b expected 1", inputc_o); end
    step();
    n_compared++;
    if (inputc_o !== 1'b0) begin n_failed++; $display("[TB] FAIL disc_credit_end: got %b expected 0", inputc_o); end
  endtask

  task automatic test_midreset();
    push(HEAD, dd(16'h3E57, 2'd2, 2'd1));
    grant_one();
    push(BODY, 32'h0BAD_0BAD);
    #2;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL mid_req: got %b expected 0", req_o); end
    n_compared++;
    if (port_o !== 5'b0) begin n_failed++; $display("[TB] FAIL mid_port: got %b expected 00000", port_o); end
    n_compared++;
    if (wire_o !== 35'b0) begin n_failed++; $display("[TB] FAIL mid_wire: got %h expected 0", wire_o); end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_compared++;
    if (inputc_o !== 1'b0) begin n_failed++; $display("[TB] FAIL mid_no_credit: got %b expected 0", inputc_o); end
    n_compared++;
    if (req_o !== 1'b0) begin n_failed++; $display("[TB] FAIL mid_flushed: got %b expected 0", req_o); end
    push(HEAD, dd(16'h4E11, 2'd1, 2'd2));
    n_compared++;
    if (port_o !== 5'b00010) begin n_failed++; $display("[TB] FAIL mid_new_route: got %b expected 00010", port_o); end
    grant_one();
    push(TAIL, 32'h0000_0E4D);
    grant_one();
    n_compared++;
    if (port_o !== 5'b0) begin n_failed++; $display("[TB] FAIL mid_idle_port: got %b expected 00000", port_o); end
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    test_reset();
    test_head_tail_east();
    test_routes();
    test_packet();
    test_overflow();
    test_full_write();
    test_discard();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
